// File: rtl/opfetch_pkg.sv
// ============================================================================
// Module  : opfetch_pkg
// Purpose : Shared types and constants for the operand-fetch stage.
//           - state_t  : stage occupancy (EMPTY, WAIT, FULL)
//           - REG_ZERO : index of the hardwired-zero register
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package opfetch_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    WAIT  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int unsigned REG_ZERO = 0;

endpackage

`default_nettype wire

// File: rtl/opfetch_scoreboard.sv
// ============================================================================
// Module  : opfetch_scoreboard
// Purpose : Per-register busy vector tracking in-flight destination writes.
//           Index 0 is hardwired to "not busy".
// Ports   : clk, rst                    clock, async active-high reset
//           set_en_i / set_idx_i        mark a register busy (issue)
//           clr_en_i / clr_idx_i        mark a register free (writeback)
//           q1_idx_i / q1_busy_o        source-1 hazard query
//           q2_idx_i / q2_busy_o        source-2 hazard query
//           qd_idx_i / qd_busy_o        destination hazard query
// Config  : OPFETCH_BYPASS_EN - queries ignore a register that is being
//           cleared in the same cycle (same-cycle writeback release).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module opfetch_scoreboard
  import opfetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en_i,
  input  logic [ADDR_WIDTH-1:0] set_idx_i,
  input  logic                  clr_en_i,
  input  logic [ADDR_WIDTH-1:0] clr_idx_i,
  input  logic [ADDR_WIDTH-1:0] q1_idx_i,
  input  logic [ADDR_WIDTH-1:0] q2_idx_i,
  input  logic [ADDR_WIDTH-1:0] qd_idx_i,
  output logic                  q1_busy_o,
  output logic                  q2_busy_o,
  output logic                  qd_busy_o
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] busy_eff;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en_i) set_vec[set_idx_i] = 1'b1;
    if (clr_en_i) clr_vec[clr_idx_i] = 1'b1;
  end

  // Clear first, then set: an issue and a writeback to the same register in
  // one cycle leave it busy (the new producer is still outstanding).
  always_comb begin
    busy_d = (busy_q & ~clr_vec) | set_vec;
    busy_d[ADDR_WIDTH'(REG_ZERO)] = 1'b0;
  end

`ifdef OPFETCH_BYPASS_EN
  // A register being written back right now counts as free; the operand is
  // forwarded from the writeback bus by the stage.
  assign busy_eff = busy_q & ~clr_vec;
`else
  assign busy_eff = busy_q;
`endif

  assign q1_busy_o = busy_eff[q1_idx_i];
  assign q2_busy_o = busy_eff[q2_idx_i];
  assign qd_busy_o = busy_eff[qd_idx_i];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

endmodule

`default_nettype wire

// File: rtl/operand_fetch.sv
// ============================================================================
// Module  : operand_fetch
// Purpose : One-entry operand-fetch stage between decode and execute. Reads
//           source operands from the register file, stalls on RAW/WAW hazards
//           via a per-register scoreboard and issues to execute.
// Ports   : clk, rst                         clock, async active-high reset
//           flush                            discard the held instruction
//           in_valid/in_ready, in_pc, in_rs1, in_rs2, in_rd, in_rd_wen
//                                            decode-side handshake + fields
//           rf_raddr1/2, rf_rdata1/2         register-file read ports
//           wb_valid, wb_rd, wb_data         writeback bus
//           out_valid/out_ready, out_pc, out_rs1_val, out_rs2_val,
//           out_rd, out_rd_wen               execute-side handshake + fields
//           stall                            hazard is blocking issue
// Config  : OPFETCH_BYPASS_EN - same-cycle writeback releases a waiting
//           instruction and forwards wb_data as its operand. Undefined: the
//           release happens one cycle later and operands come from the RF.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module operand_fetch
  import opfetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PC_WIDTH-1:0]   in_pc,
  input  logic [ADDR_WIDTH-1:0] in_rs1,
  input  logic [ADDR_WIDTH-1:0] in_rs2,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_rd_wen,
  output logic [ADDR_WIDTH-1:0] rf_raddr1,
  output logic [ADDR_WIDTH-1:0] rf_raddr2,
  input  logic [DATA_WIDTH-1:0] rf_rdata1,
  input  logic [DATA_WIDTH-1:0] rf_rdata2,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [DATA_WIDTH-1:0] out_rs1_val,
  output logic [DATA_WIDTH-1:0] out_rs2_val,
  output logic [ADDR_WIDTH-1:0] out_rd,
  output logic                  out_rd_wen,
  output logic                  stall
);

  state_t                state_q;

  // Instruction held while its operands are resolved
  logic [PC_WIDTH-1:0]   pc_q;
  logic [ADDR_WIDTH-1:0] rs1_q;
  logic [ADDR_WIDTH-1:0] rs2_q;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic                  rd_wen_q;

  // Output registers presented to execute
  logic [PC_WIDTH-1:0]   out_pc_q;
  logic [DATA_WIDTH-1:0] out_rs1_q;
  logic [DATA_WIDTH-1:0] out_rs2_q;
  logic [ADDR_WIDTH-1:0] out_rd_q;
  logic                  out_rd_wen_q;

  logic                  w_rs1_busy;
  logic                  w_rs2_busy;
  logic                  w_rd_busy;
  logic                  w_hazard;
  logic                  w_capture;
  logic                  w_issue;
  logic                  w_set_en;
  logic [DATA_WIDTH-1:0] w_op1;
  logic [DATA_WIDTH-1:0] w_op2;

  assign rf_raddr1 = rs1_q;
  assign rf_raddr2 = rs2_q;

  assign w_hazard = w_rs1_busy | w_rs2_busy | (rd_wen_q & w_rd_busy);

  // flush suppresses both handshakes in its cycle, so neither side can
  // believe a transfer happened that the stage then discards.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      EMPTY:   in_ready = 1'b1;
      FULL:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    in_ready = in_ready & ~flush & ~rst;
  end

  assign out_valid = (state_q == FULL) & ~flush;
  assign stall     = (state_q == WAIT) & w_hazard;
  assign w_capture = in_valid & in_ready;
  assign w_issue   = out_valid & out_ready;
  assign w_set_en  = w_issue & out_rd_wen_q & (out_rd_q != ADDR_WIDTH'(REG_ZERO));

`ifdef OPFETCH_BYPASS_EN
  always_comb begin
    w_op1 = rf_rdata1;
    w_op2 = rf_rdata2;
    if (wb_valid && (wb_rd == rs1_q) && (rs1_q != ADDR_WIDTH'(REG_ZERO))) w_op1 = wb_data;
    if (wb_valid && (wb_rd == rs2_q) && (rs2_q != ADDR_WIDTH'(REG_ZERO))) w_op2 = wb_data;
  end
`else
  // wb_data reaches the register file externally; this stage never needs it.
  logic w_unused_wb_data;
  assign w_unused_wb_data = ^wb_data;
  assign w_op1 = rf_rdata1;
  assign w_op2 = rf_rdata2;
`endif

  opfetch_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_en_i  (w_set_en),
    .set_idx_i (out_rd_q),
    .clr_en_i  (wb_valid),
    .clr_idx_i (wb_rd),
    .q1_idx_i  (rs1_q),
    .q2_idx_i  (rs2_q),
    .qd_idx_i  (rd_q),
    .q1_busy_o (w_rs1_busy),
    .q2_busy_o (w_rs2_busy),
    .qd_busy_o (w_rd_busy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      pc_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      rd_wen_q     <= 1'b0;
      out_pc_q     <= '0;
      out_rs1_q    <= '0;
      out_rs2_q    <= '0;
      out_rd_q     <= '0;
      out_rd_wen_q <= 1'b0;
    end else begin
      if (w_capture) begin
        pc_q     <= in_pc;
        rs1_q    <= in_rs1;
        rs2_q    <= in_rs2;
        rd_q     <= in_rd;
        rd_wen_q <= in_rd_wen;
      end
      if (flush) begin
        state_q <= EMPTY;
      end else begin
        case (state_q)
          EMPTY: if (w_capture) state_q <= WAIT;
          WAIT: begin
            if (!w_hazard) begin
              out_pc_q     <= pc_q;
              out_rs1_q    <= w_op1;
              out_rs2_q    <= w_op2;
              out_rd_q     <= rd_q;
              out_rd_wen_q <= rd_wen_q;
              state_q      <= FULL;
            end
          end
          FULL: begin
            if (w_issue) state_q <= w_capture ? WAIT : EMPTY;
          end
          default: state_q <= EMPTY;
        endcase
      end
    end
  end

  assign out_pc      = out_pc_q;
  assign out_rs1_val = out_rs1_q;
  assign out_rs2_val = out_rs2_q;
  assign out_rd      = out_rd_q;
  assign out_rd_wen  = out_rd_wen_q;

endmodule

`default_nettype wire
